bcd_seg_scan: RTL and testbench

BCD_SEG_SCAN -- requirements
Module: bcd_seg_scan

---
 rtl/bcd_seg_scan_pkg.sv | 46 ++++
 rtl/bcd_seg_scan_if.sv | 16 +
 rtl/bcd_seg_decode.sv | 30 +++
 rtl/bcd_seg_scan.sv | 130 +++++++++++++
 tb/tb_bcd_seg_scan.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/bcd_seg_scan_pkg.sv
// Shared types and constants for the BCD converter and 7-segment scanner.
// Leading-zero suppression (LEADING_ZERO_BLANK_EN) uses lead_blank() below.
package seg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int BCD_DIGITS = 5;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  // Active-low segments: bit0..6 = a..g, bit7 = dp (kept off)
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Double-dabble correction: add 3 to every nibble that is 5 or more
  function automatic logic [4*BCD_DIGITS-1:0] add3_nibbles(input logic [4*BCD_DIGITS-1:0] bcd);
    logic [4*BCD_DIGITS-1:0] r;
    r = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Blank flags for zero digits above the most significant nonzero one; digit 0 never blanks
  function automatic logic [BCD_DIGITS-1:0] lead_blank(input logic [4*BCD_DIGITS-1:0] bcd);
    logic [BCD_DIGITS-1:0] b;
    logic above;
    b     = '0;
    above = 1'b1;
    for (int i = BCD_DIGITS - 1; i >= 1; i--) begin
      above = above && (bcd[4*i +: 4] == 4'd0);
      b[i]  = above;
    end
    return b;
  endfunction

endpackage

// File: rtl/bcd_seg_scan_if.sv
// Conversion request/status and display drive bundle for bcd_seg_scan.
interface bcd_seg_scan_if;
  import seg_pkg::*;

  logic [15:0]           d_in;
  logic                  d_valid;
  logic                  busy;
  logic                  conv_done;
  logic [NUM_DIGITS-1:0] seg_position;
  logic [7:0]            seg_data;

  modport master (output d_in, d_valid,
                  input  busy, conv_done, seg_position, seg_data);
  modport slave  (input  d_in, d_valid,
                  output busy, conv_done, seg_position, seg_data);
endinterface

// File: rtl/bcd_seg_decode.sv
// Combinational BCD digit to active-low 7-segment code; blank flag wins.
module bcd_seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [7:0] seg
);

  // NOTE: default assigned before the case so no path leaves seg unassigned (no latch).
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// 16-bit binary to 5-digit BCD (double-dabble) feeding a free-running 8-digit scanner.
// Define LEADING_ZERO_BLANK_EN to suppress leading zeros on digits 1..4.
module bcd_seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic           clk,
  input  logic           rst,
  bcd_seg_scan_if.slave  bus
);

  state_t state, state_nxt;
  logic   load, shift_en, commit;

  logic [15:0]             bin_q;
  logic [4*BCD_DIGITS-1:0] bcd_q;
  logic [4:0]              cnt_q;
  logic                    conv_done_q;

  logic [3:0]              disp_digit [BCD_DIGITS];
  logic [BCD_DIGITS-1:0]   disp_blank;

  logic [15:0]             presc_q;
  logic [2:0]              scan_idx;
  logic [NUM_DIGITS-1:0]   seg_position_q;
  logic [7:0]              seg_data_q;
  logic [3:0]              sel_digit;
  logic                    sel_blank;
  logic [7:0]              dec_seg;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift_en  = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: if (bus.d_valid) begin
        load      = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt_q == 5'd15) state_nxt = COMMIT;
      end
      COMMIT: begin
        commit    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the small display register file is reset explicitly so it powers up blank.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bin_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      conv_done_q <= 1'b0;
      disp_blank  <= '1;
      for (int i = 0; i < BCD_DIGITS; i++) disp_digit[i] <= 4'd0;
    end else begin
      conv_done_q <= commit;
      if (load) begin
        bin_q <= bus.d_in;
        bcd_q <= '0;
        cnt_q <= '0;
      end else if (shift_en) begin
        {bcd_q, bin_q} <= {add3_nibbles(bcd_q), bin_q} << 1;
        cnt_q          <= cnt_q + 5'd1;
      end
      if (commit) begin
        for (int i = 0; i < BCD_DIGITS; i++) disp_digit[i] <= bcd_q[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        disp_blank <= lead_blank(bcd_q);
`else
        disp_blank <= '0;
`endif
      end
    end
  end

  // Positions above the BCD range always read as blank
  always_comb begin
    sel_digit = 4'd0;
    sel_blank = 1'b1;
    if (scan_idx < 3'(BCD_DIGITS)) begin
      sel_digit = disp_digit[scan_idx];
      sel_blank = disp_blank[scan_idx];
    end
  end

  bcd_seg_decode u_decode (
    .digit (sel_digit),
    .blank (sel_blank),
    .seg   (dec_seg)
  );

  // Scanner runs regardless of conversions; a commit never disturbs its phase
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q        <= '0;
      scan_idx       <= '0;
      seg_position_q <= 8'hFE;
      seg_data_q     <= SEG_BLANK;
    end else begin
      if (presc_q == 16'(SCAN_DIV - 1)) begin
        presc_q  <= '0;
        scan_idx <= scan_idx + 3'd1;
      end else begin
        presc_q  <= presc_q + 16'd1;
      end
      seg_position_q <= ~(8'b1 << scan_idx);
      seg_data_q     <= dec_seg;
    end
  end

  assign bus.busy         = (state != IDLE);
  assign bus.conv_done    = conv_done_q;
  assign bus.seg_position = seg_position_q;
  assign bus.seg_data     = seg_data_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Directed self-checking bench for bcd_seg_scan with SCAN_DIV=4.
module tb_bcd_seg_scan;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  bcd_seg_scan_if bus ();

  bcd_seg_scan #(.SCAN_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7:0] LZ = 8'hFF;
`else
  localparam logic [7:0] LZ = 8'hC0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the scanner to select digit k and returns its segment code
  task automatic read_digit(input int k, output logic [7:0] seg);
    logic [7:0] want;
    want = ~(8'b1 << k);
    seg  = 8'hxx;
    for (int n = 0; n < 64; n++) begin
      if (bus.seg_position === want) begin
        seg = bus.seg_data;
        return;
      end
      tick();
    end
  endtask

  task automatic check_digits(input string tag, input logic [63:0] exp);
    logic [7:0] seg;
    for (int k = 0; k < 8; k++) begin
      read_digit(k, seg);
      check($sformatf("%s_d%0d", tag, k), {24'd0, seg}, {24'd0, exp[8*k +: 8]});
    end
  endtask

  // Presents d_in for one cycle; lat = edges from d_valid launch to first conv_done high
  task automatic run_conv(input logic [15:0] v, output int lat);
    bus.d_in    = v;
    bus.d_valid = 1'b1;
    tick();
    bus.d_valid = 1'b0;
    lat = 1;
    check("busy_in_shift", {31'd0, bus.busy}, 32'd1);
    while (bus.conv_done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int done_cnt;

    rst         = 1'b0;
    bus.d_in    = '0;
    bus.d_valid = 1'b0;
    repeat (3) tick();
    check("rst_busy",      {31'd0, bus.busy},      32'd0);
    check("rst_conv_done", {31'd0, bus.conv_done}, 32'd0);
    check("rst_position",  {24'd0, bus.seg_position}, 32'hFE);
    check("rst_data",      {24'd0, bus.seg_data},  32'hFF);
    rst = 1'b1;
    tick();

    // 2451 -> digits 1,5,4,2,0
    run_conv(16'd2451, lat);
    check("lat_2451", lat, 18);
    check("busy_after_commit", {31'd0, bus.busy}, 32'd0);
    tick();
    check("done_one_cycle", {31'd0, bus.conv_done}, 32'd0);
    check_digits("v2451", {8'hFF, 8'hFF, 8'hFF, LZ, 8'hA4, 8'h99, 8'h92, 8'hF9});

    // 65535 -> digits 5,3,5,5,6
    run_conv(16'd65535, lat);
    check("lat_65535", lat, 18);
    check_digits("v65535", {8'hFF, 8'hFF, 8'hFF, 8'h82, 8'h92, 8'h92, 8'hB0, 8'h92});

    // 0 -> only digit 0 is guaranteed a numeral
    run_conv(16'd0, lat);
    check("lat_0", lat, 18);
    check_digits("v0", {8'hFF, 8'hFF, 8'hFF, LZ, LZ, LZ, LZ, 8'hC0});

    // Second request while busy must be ignored
    bus.d_in    = 16'd100;
    bus.d_valid = 1'b1;
    tick();
    bus.d_valid = 1'b0;
    repeat (4) tick();
    bus.d_in    = 16'd200;
    bus.d_valid = 1'b1;
    done_cnt    = 0;
    tick();
    bus.d_valid = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (bus.conv_done === 1'b1) done_cnt++;
      tick();
    end
    check("ignore_done_count", done_cnt, 1);
    check_digits("v100", {8'hFF, 8'hFF, 8'hFF, LZ, LZ, 8'hF9, 8'hC0, 8'hC0});

    // Reset in the middle of a conversion
    bus.d_in    = 16'd1234;
    bus.d_valid = 1'b1;
    tick();
    bus.d_valid = 1'b0;
    repeat (8) tick();
    check("busy_mid_shift", {31'd0, bus.busy}, 32'd1);
    rst = 1'b0;
    tick();
    check("abort_busy",     {31'd0, bus.busy},         32'd0);
    check("abort_done",     {31'd0, bus.conv_done},    32'd0);
    check("abort_position", {24'd0, bus.seg_position}, 32'hFE);
    check("abort_data",     {24'd0, bus.seg_data},     32'hFF);
    rst = 1'b1;

    // Free-running scan from reset, display must stay blank
    done_cnt = 0;
    for (int j = 0; j < 36; j++) begin
      tick();
      if (bus.conv_done === 1'b1) done_cnt++;
      check($sformatf("scan_pos_%0d", j), {24'd0, bus.seg_position},
            {24'd0, ~(8'b1 << ((j / 4) % 8))});
      check($sformatf("scan_blank_%0d", j), {24'd0, bus.seg_data}, 32'hFF);
    end
    check("abort_no_done", done_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
